// File: rtl/sysbus_arbiter.sv
// sysbus_arbiter: grants one of two Top-style clients access to a single
// Sysbus Top port and keeps the bus locked until that client's transaction
// (one address beat plus its write-data or read-response beats) completes.
module sysbus_arbiter #(
  parameter int DATA_WIDTH  = 64,
  parameter int TAG_WIDTH   = 13,
  parameter int READ_BEATS  = 8,
  parameter int WRITE_BEATS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] c0_req,
  input  logic [TAG_WIDTH-1:0]  c0_reqtag,
  input  logic                  c0_reqcyc,
  output logic                  c0_reqack,
  output logic [DATA_WIDTH-1:0] c0_resp,
  output logic [TAG_WIDTH-1:0]  c0_resptag,
  output logic                  c0_respcyc,
  input  logic                  c0_respack,
  input  logic [DATA_WIDTH-1:0] c1_req,
  input  logic [TAG_WIDTH-1:0]  c1_reqtag,
  input  logic                  c1_reqcyc,
  output logic                  c1_reqack,
  output logic [DATA_WIDTH-1:0] c1_resp,
  output logic [TAG_WIDTH-1:0]  c1_resptag,
  output logic                  c1_respcyc,
  input  logic                  c1_respack,
  output logic [DATA_WIDTH-1:0] bus_req,
  output logic [TAG_WIDTH-1:0]  bus_reqtag,
  output logic                  bus_reqcyc,
  input  logic                  bus_reqack,
  input  logic [DATA_WIDTH-1:0] bus_resp,
  input  logic [TAG_WIDTH-1:0]  bus_resptag,
  input  logic                  bus_respcyc,
  output logic                  bus_respack,
  output logic                  err
);

  localparam int MAX_BEATS = (READ_BEATS > WRITE_BEATS) ? READ_BEATS : WRITE_BEATS;
  localparam int CW        = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0] LAST_RD = CW'(READ_BEATS - 1);
  localparam logic [CW-1:0] LAST_WR = CW'(WRITE_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    WDATA = 2'd2,
    RDATA = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic            owner_reg, owner_next;
  logic            last_reg, last_next;
  logic [CW-1:0]   count_reg, count_next;
  logic            err_reg, err_next;

  // Owner's request side and response-accept, selected by the registered owner
  logic [DATA_WIDTH-1:0] own_req;
  logic [TAG_WIDTH-1:0]  own_reqtag;
  logic                  own_reqcyc;
  logic                  own_respack;
  logic                  req_xfer;
  logic                  resp_xfer;
  logic                  grant;

  assign own_req     = owner_reg ? c1_req     : c0_req;
  assign own_reqtag  = owner_reg ? c1_reqtag  : c0_reqtag;
  assign own_reqcyc  = owner_reg ? c1_reqcyc  : c0_reqcyc;
  assign own_respack = owner_reg ? c1_respack : c0_respack;
  assign req_xfer    = own_reqcyc & bus_reqack;
  assign resp_xfer   = bus_respcyc & own_respack;

  // Tie goes to the client that was not granted last; otherwise the lone requester
  assign grant = (c0_reqcyc & c1_reqcyc) ? ~last_reg : c1_reqcyc;

  assign err = err_reg;

  // State register and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      owner_reg <= 1'b0;
      last_reg  <= 1'b1;
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      last_reg  <= last_next;
      count_reg <= count_next;
      err_reg   <= err_next;
    end
  end

  // Next-state logic: arbitration, beat counting and stray-response detection
  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    last_next  = last_reg;
    count_next = count_reg;
    err_next   = err_reg | (bus_respcyc & (state_reg != RDATA));
    case (state_reg)
      IDLE: begin
        if (c0_reqcyc | c1_reqcyc) begin
          owner_next = grant;
          last_next  = grant;
          state_next = ADDR;
        end
      end
      ADDR: begin
        if (req_xfer) begin
          count_next = '0;
          state_next = own_reqtag[TAG_WIDTH-1] ? RDATA : WDATA;
        end
      end
      WDATA: begin
        if (req_xfer) begin
          if (count_reg == LAST_WR) begin
            count_next = '0;
            state_next = IDLE;
          end else begin
            count_next = count_reg + 1'b1;
          end
        end
      end
      RDATA: begin
        if (resp_xfer) begin
          if (count_reg == LAST_RD) begin
            count_next = '0;
            state_next = IDLE;
          end else begin
            count_next = count_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output routing: forward only between the owner and the bus in the matching state
  always_comb begin
    bus_req     = '0;
    bus_reqtag  = '0;
    bus_reqcyc  = 1'b0;
    bus_respack = bus_respcyc;
    c0_reqack   = 1'b0;
    c1_reqack   = 1'b0;
    c0_resp     = '0;
    c0_resptag  = '0;
    c0_respcyc  = 1'b0;
    c1_resp     = '0;
    c1_resptag  = '0;
    c1_respcyc  = 1'b0;
    case (state_reg)
      ADDR, WDATA: begin
        bus_req    = own_req;
        bus_reqtag = own_reqtag;
        bus_reqcyc = own_reqcyc;
        if (owner_reg) c1_reqack = bus_reqack;
        else           c0_reqack = bus_reqack;
      end
      RDATA: begin
        bus_respack = own_respack;
        if (owner_reg) begin
          c1_resp    = bus_resp;
          c1_resptag = bus_resptag;
          c1_respcyc = bus_respcyc;
        end else begin
          c0_resp    = bus_resp;
          c0_resptag = bus_resptag;
          c0_respcyc = bus_respcyc;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Directed bench for sysbus_arbiter: the stimulus tasks play both clients and
// the bus, pushing every expected bus-request beat and client-response beat
// into queues; a negedge monitor pops and compares each transferred beat.
module tb_sysbus_arbiter;

  logic        clk;
  logic        reset;
  logic [63:0] creq [2];
  logic [12:0] creqtag [2];
  logic [1:0]  creqcyc;
  logic [1:0]  creqack;
  logic [63:0] cresp [2];
  logic [12:0] cresptag [2];
  logic [1:0]  crespcyc;
  logic [1:0]  crespack;
  logic [63:0] bus_req;
  logic [12:0] bus_reqtag;
  logic        bus_reqcyc;
  logic        bus_reqack;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;
  logic        bus_respcyc;
  logic        bus_respack;
  logic        err;

  int compared = 0;
  int mismatched = 0;

  logic [76:0] bus_q [$];
  logic [76:0] rq0 [$];
  logic [76:0] rq1 [$];

  sysbus_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .c0_req      (creq[0]),
    .c0_reqtag   (creqtag[0]),
    .c0_reqcyc   (creqcyc[0]),
    .c0_reqack   (creqack[0]),
    .c0_resp     (cresp[0]),
    .c0_resptag  (cresptag[0]),
    .c0_respcyc  (crespcyc[0]),
    .c0_respack  (crespack[0]),
    .c1_req      (creq[1]),
    .c1_reqtag   (creqtag[1]),
    .c1_reqcyc   (creqcyc[1]),
    .c1_reqack   (creqack[1]),
    .c1_resp     (cresp[1]),
    .c1_resptag  (cresptag[1]),
    .c1_respcyc  (crespcyc[1]),
    .c1_respack  (crespack[1]),
    .bus_req     (bus_req),
    .bus_reqtag  (bus_reqtag),
    .bus_reqcyc  (bus_reqcyc),
    .bus_reqack  (bus_reqack),
    .bus_resp    (bus_resp),
    .bus_resptag (bus_resptag),
    .bus_respcyc (bus_respcyc),
    .bus_respack (bus_respack),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [76:0] act, input logic [76:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_resp(input int cl, input logic [76:0] v);
    if (cl == 0) rq0.push_back(v);
    else         rq1.push_back(v);
  endtask

  function automatic logic any_out();
    return |{bus_req, bus_reqtag, bus_reqcyc, bus_respack, creqack, crespcyc, err,
             cresp[0], cresp[1], cresptag[0], cresptag[1]};
  endfunction

  // Monitor: compare every beat that transfers on the bus request side or to a client
  always @(negedge clk) begin
    if (reset && bus_reqcyc && bus_reqack) begin
      if (bus_q.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL bus_beat_unexpected: got %h, expected none", {bus_req, bus_reqtag});
      end else begin
        chk("bus_beat", {bus_req, bus_reqtag}, bus_q.pop_front());
      end
    end
    if (crespcyc[0]) begin
      if (rq0.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL c0_resp_unexpected: got %h, expected none", {cresp[0], cresptag[0]});
      end else if (crespack[0]) begin
        chk("c0_resp", {cresp[0], cresptag[0]}, rq0.pop_front());
      end
    end
    if (crespcyc[1]) begin
      if (rq1.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL c1_resp_unexpected: got %h, expected none", {cresp[1], cresptag[1]});
      end else if (crespack[1]) begin
        chk("c1_resp", {cresp[1], cresptag[1]}, rq1.pop_front());
      end
    end
  end

  // One complete transaction for client cl, starting with the block in IDLE
  task automatic bus_txn(input int cl, input bit rd, input logic [63:0] addr,
                         input logic [12:0] tag, input logic [63:0] dbase,
                         input int ack_dly, input int bp_at, input int abort_at,
                         input bit hold);
    int oc;
    oc = 1 - cl;
    creq[cl]    = addr;
    creqtag[cl] = tag;
    creqcyc[cl] = 1'b1;
    #1 chk("idle_bubble", 77'(bus_reqcyc), 77'(0));
    bus_q.push_back({addr, tag});
    tick();
    for (int i = 0; i < ack_dly; i++) begin
      chk("addr_wait_ack", 77'(creqack), 77'(0));
      tick();
    end
    bus_reqack = 1'b1;
    #1 chk("addr_ack_route", 77'({creqack[cl], creqack[oc]}), 77'(2'b10));
    tick();
    bus_reqack = 1'b0;
    if (!rd) begin
      for (int i = 0; i < 8; i++) begin
        creq[cl] = dbase + 64'(i);
        bus_q.push_back({dbase + 64'(i), tag});
        #1 chk("wr_mirror_lo", 77'(creqack), 77'(0));
        tick();
        bus_reqack = 1'b1;
        #1 chk("wr_mirror_hi", 77'({creqack[cl], creqack[oc]}), 77'(2'b10));
        tick();
        bus_reqack = 1'b0;
      end
      bus_reqack = 1'b1;
      #1 chk("wr_done_idle", 77'(creqack), 77'(0));
      bus_reqack = 1'b0;
      if (!hold) creqcyc[cl] = 1'b0;
    end else begin
      if (!hold) creqcyc[cl] = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (i == abort_at) begin
          reset       = 1'b0;
          bus_respcyc = 1'b0;
          tick();
          chk("abort_outs_zero", 77'(any_out()), 77'(0));
          chk("abort_err_clear", 77'(err), 77'(0));
          reset = 1'b1;
          return;
        end
        bus_respcyc = 1'b1;
        bus_resp    = dbase + 64'(i);
        bus_resptag = tag;
        push_resp(cl, {dbase + 64'(i), tag});
        if (i == bp_at) begin
          crespack[cl] = 1'b0;
          for (int j = 0; j < 3; j++) begin
            #1 chk("bp_respack", 77'(bus_respack), 77'(0));
            tick();
          end
          crespack[cl] = 1'b1;
        end
        tick();
      end
      bus_respcyc = 1'b0;
      #1 chk("rd_done_idle", 77'(bus_respack), 77'(0));
    end
  endtask

  initial begin
    reset       = 1'b0;
    creq[0]     = '0; creq[1] = '0;
    creqtag[0]  = '0; creqtag[1] = '0;
    creqcyc     = 2'b00;
    crespack    = 2'b11;
    bus_reqack  = 1'b0;
    bus_resp    = '0;
    bus_resptag = '0;
    bus_respcyc = 1'b0;
    tick();
    tick();
    chk("reset_outs_zero", 77'(any_out()), 77'(0));
    chk("reset_err", 77'(err), 77'(0));
    reset = 1'b1;
    tick();

    // Single read from c0, bus acks the address after 2 cycles
    bus_txn(0, 1'b1, 64'h1000, 13'h1001, 64'hA0, 2, 99, 99, 1'b0);
    tick();
    // Single write from c1, address then 8 data beats with toggling ack
    bus_txn(1, 1'b0, 64'h2000, 13'h0022, 64'hB0, 1, 99, 99, 1'b0);
    tick();

    // Tie round-robin from reset: both clients request continuously
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rr_reset_outs", 77'(any_out()), 77'(0));
    creq[1] = 64'h4000; creqtag[1] = 13'h1004; creqcyc[1] = 1'b1;
    bus_txn(0, 1'b1, 64'h3000, 13'h1003, 64'hC0, 0, 99, 99, 1'b1);
    bus_txn(1, 1'b1, 64'h4000, 13'h1004, 64'hD0, 0, 99, 99, 1'b1);
    bus_txn(0, 1'b1, 64'h3100, 13'h1013, 64'hC8, 0, 99, 99, 1'b1);
    bus_txn(1, 1'b1, 64'h4100, 13'h1014, 64'hD8, 0, 99, 99, 1'b0);
    creqcyc = 2'b00;
    tick();

    // Backpressure: c0 withholds respack for 3 cycles at beat 4
    bus_txn(0, 1'b1, 64'h5000, 13'h1005, 64'hE0, 1, 4, 99, 1'b0);
    tick();

    // Stray response beat while idle
    chk("stray_err_before", 77'(err), 77'(0));
    bus_respcyc = 1'b1;
    bus_resp    = 64'hDEAD;
    bus_resptag = 13'h1FFF;
    #1 chk("stray_respack", 77'(bus_respack), 77'(1));
    tick();
    bus_respcyc = 1'b0;
    #1 chk("stray_err_next", 77'(err), 77'(1));
    tick();
    tick();
    chk("stray_err_sticky", 77'(err), 77'(1));

    // Reset mid-read after 3 beats, then a normal c1 read
    bus_txn(0, 1'b1, 64'h6000, 13'h1006, 64'hF0, 0, 99, 3, 1'b0);
    tick();
    bus_txn(1, 1'b1, 64'h7000, 13'h1007, 64'h70, 1, 99, 99, 1'b0);
    tick();
    tick();

    chk("bus_q_drained", 77'(bus_q.size()), 77'(0));
    chk("c0_q_drained", 77'(rq0.size()), 77'(0));
    chk("c1_q_drained", 77'(rq1.size()), 77'(0));
    chk("final_err", 77'(err), 77'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
